// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter sharing one register-file write port between requesters A and B.
// Optional grant/conflict statistics outputs are enabled with `define RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
   parameter int pw = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [pw-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [pw-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          wr_en,
   output logic [pw-1:0] wr_addr,
   output logic [DW-1:0] dat_in,
   input  logic [pw-1:0] rd_addrA,
   input  logic [pw-1:0] rd_addrB,
   output logic          hazard
`ifdef RF_WB_ARB_STATS_EN
   ,
   output logic [15:0]   grant_cnt_a,
   output logic [15:0]   grant_cnt_b,
   output logic [15:0]   conflict_cnt
`endif
);

   typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} grant_t;

   grant_t        grant;
   logic          a_full, b_full;
   logic [pw-1:0] a_addr_q, b_addr_q;
   logic [DW-1:0] a_data_q, b_data_q;
   logic          age;     // 1: A's slot holds the older write
   logic          last_b;  // 1: previous grant went to B
   logic          a_load, b_load, a_keep, b_keep;

   // Grant depends on slot state only, never on the incoming valids.
   always_comb begin
      grant = GNT_NONE;
      if (a_full && b_full) begin
         if (a_addr_q == b_addr_q) grant = age ? GNT_A : GNT_B;
         else                      grant = last_b ? GNT_A : GNT_B;
      end else if (a_full) begin
         grant = GNT_A;
      end else if (b_full) begin
         grant = GNT_B;
      end
   end

   always_comb begin
      a_ready = !a_full || (grant == GNT_A);
      b_ready = !b_full || (grant == GNT_B);
      a_load  = a_valid && a_ready;
      b_load  = b_valid && b_ready;
      a_keep  = a_full && (grant != GNT_A);
      b_keep  = b_full && (grant != GNT_B);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_full   <= 1'b0;
         b_full   <= 1'b0;
         a_addr_q <= '0;
         b_addr_q <= '0;
         a_data_q <= '0;
         b_data_q <= '0;
         age      <= 1'b0;
         last_b   <= 1'b1;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         dat_in   <= '0;
      end else begin
         if (a_load) begin
            a_full   <= 1'b1;
            a_addr_q <= a_addr;
            a_data_q <= a_data;
         end else if (grant == GNT_A) begin
            a_full <= 1'b0;
         end
         if (b_load) begin
            b_full   <= 1'b1;
            b_addr_q <= b_addr;
            b_data_q <= b_data;
         end else if (grant == GNT_B) begin
            b_full <= 1'b0;
         end
         // Simultaneous loads count A as older so B's value lands last.
         if (a_load && b_load)      age <= 1'b1;
         else if (a_load && b_keep) age <= 1'b0;
         else if (b_load && a_keep) age <= 1'b1;
         unique case (grant)
            GNT_A: begin
               wr_en   <= 1'b1;
               wr_addr <= a_addr_q;
               dat_in  <= a_data_q;
               last_b  <= 1'b0;
            end
            GNT_B: begin
               wr_en   <= 1'b1;
               wr_addr <= b_addr_q;
               dat_in  <= b_data_q;
               last_b  <= 1'b1;
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

   always_comb begin
      hazard = (a_full && ((a_addr_q == rd_addrA) || (a_addr_q == rd_addrB))) ||
               (b_full && ((b_addr_q == rd_addrA) || (b_addr_q == rd_addrB))) ||
               (wr_en  && ((wr_addr  == rd_addrA) || (wr_addr  == rd_addrB)));
   end

`ifdef RF_WB_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_a  <= '0;
         grant_cnt_b  <= '0;
         conflict_cnt <= '0;
      end else begin
         if (grant == GNT_A)  grant_cnt_a  <= grant_cnt_a + 16'd1;
         if (grant == GNT_B)  grant_cnt_b  <= grant_cnt_b + 16'd1;
         if (a_full && b_full) conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: timestamp-based slot model predicts writes,
// a separate monitor checks the registered write port; stats checked under RF_WB_ARB_STATS_EN.
module tb_rf_wb_arbiter;
   localparam int PW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_valid, b_valid, a_ready, b_ready;
   logic [PW-1:0] a_addr, b_addr, rd_addrA, rd_addrB, wr_addr;
   logic [DW-1:0] a_data, b_data, dat_in;
   logic          wr_en, hazard;
`ifdef RF_WB_ARB_STATS_EN
   logic [15:0]   grant_cnt_a, grant_cnt_b, conflict_cnt;
`endif

   rf_wb_arbiter #(.pw(PW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .hazard(hazard)
`ifdef RF_WB_ARB_STATS_EN
      , .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            full;
      logic [PW-1:0] addr;
      logic [DW-1:0] data;
      int            t;
   } slot_t;

   typedef struct {
      logic [PW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   int            tests = 0;
   int            fails = 0;
   wr_t           exp_q[$];
   slot_t         ma, mb;
   int            now;
   bit            m_last_b;
   bit            m_wr_en;
   logic [PW-1:0] m_wr_addr;
   int            m_cnt_a, m_cnt_b, m_conf;
   logic [DW-1:0] exp_rf [16];
   logic [DW-1:0] dut_rf [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
      now = 1;
      m_last_b = 1'b1;
      m_wr_en = 1'b0;
      m_wr_addr = '0;
      m_cnt_a = 0; m_cnt_b = 0; m_conf = 0;
   endtask

   // 0 none, 1 A, 2 B: older load wins on equal address, else the opposite of the last winner.
   function automatic int mgrant();
      if (!ma.full && !mb.full) return 0;
      if (ma.full && !mb.full) return 1;
      if (!ma.full && mb.full) return 2;
      if (ma.addr == mb.addr) return (ma.t <= mb.t) ? 1 : 2;
      return m_last_b ? 1 : 2;
   endfunction

   task automatic cycle(input bit av, input logic [PW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [PW-1:0] ba, input logic [DW-1:0] bd,
                        input logic [PW-1:0] ra, input logic [PW-1:0] rb);
      int g;
      bit ear, ebr, ehz, ha, hb;
      @(negedge clk);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      rd_addrA = ra; rd_addrB = rb;
      #1;
      g   = mgrant();
      ear = !ma.full || (g == 1);
      ebr = !mb.full || (g == 2);
      ehz = (ma.full && (ma.addr == ra || ma.addr == rb)) ||
            (mb.full && (mb.addr == ra || mb.addr == rb)) ||
            (m_wr_en && (m_wr_addr == ra || m_wr_addr == rb));
      chk("a_ready", {31'd0, a_ready}, {31'd0, ear});
      chk("b_ready", {31'd0, b_ready}, {31'd0, ebr});
      chk("hazard",  {31'd0, hazard},  {31'd0, ehz});
      ha = av && ear;
      hb = bv && ebr;
      if (ma.full && mb.full) m_conf++;
      if (g == 1) begin
         exp_q.push_back('{ma.addr, ma.data});
         exp_rf[ma.addr] = ma.data;
         m_wr_addr = ma.addr; m_last_b = 1'b0; m_cnt_a++; ma.full = 0;
      end else if (g == 2) begin
         exp_q.push_back('{mb.addr, mb.data});
         exp_rf[mb.addr] = mb.data;
         m_wr_addr = mb.addr; m_last_b = 1'b1; m_cnt_b++; mb.full = 0;
      end
      m_wr_en = (g != 0);
      if (ha) ma = '{1, aa, ad, now};
      if (hb) mb = '{1, ba, bd, now};
      now++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 4'hF, 4'hE);
   endtask

   // Reset asserted at a negedge while slots are full; outputs must clear immediately.
   task automatic do_reset();
      @(negedge clk);
      rd_addrA = 4'd1; rd_addrB = 4'd2;
      rst_n = 1'b0;
      a_valid = 0; b_valid = 0;
      #1;
      chk("rst_wr_en",   {31'd0, wr_en},   32'd0);
      chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
      chk("rst_hazard",  {31'd0, hazard},  32'd0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every registered write must match the next expected entry, one cycle after grant.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (wr_en) begin
               dut_rf[wr_addr] = dat_in;
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", {28'd0, wr_addr}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
                  chk("dat_in",  {24'd0, dat_in},  {24'd0, e.data});
               end
            end else if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("missing_write", 32'd0, {24'd0, e.data});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
      rd_addrA = 4'hF; rd_addrB = 4'hE;
      for (int i = 0; i < 16; i++) begin exp_rf[i] = '0; dut_rf[i] = '0; end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_wr_en",   {31'd0, wr_en},   32'd0);
      chk("init_wr_addr", {28'd0, wr_addr}, 32'd0);
      chk("init_dat_in",  {24'd0, dat_in},  32'd0);
      chk("init_a_ready", {31'd0, a_ready}, 32'd1);
      chk("init_b_ready", {31'd0, b_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester, back-to-back.
      cycle(1, 3, 8'h11, 0, 0, 0, 4'hF, 4'hE);
      cycle(1, 4, 8'h22, 0, 0, 0, 4'hF, 4'hE);
      cycle(1, 5, 8'h33, 0, 0, 0, 4'hF, 4'hE);
      idle(3);

      // Distinct-address contention after reset: A first, then alternation.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 1, 8'(8'h40 + i), 1, 2, 8'(8'h80 + i), 4'hF, 4'hE);
      do_reset();
      idle(3);

      // Same address, same cycle: A then B, r7 ends at 0xBB.
      cycle(1, 7, 8'hAA, 1, 7, 8'hBB, 4'hF, 4'hE);
      idle(4);
      chk("r7_final", {24'd0, dut_rf[7]}, 32'hBB);

      // Same address, B loaded first while A is blocked; r5 ends at 0x02.
      cycle(1, 1, 8'h10, 1, 2, 8'h20, 4'hF, 4'hE);
      cycle(1, 3, 8'h30, 0, 0, 0,     4'hF, 4'hE);
      cycle(1, 5, 8'h02, 1, 5, 8'h01, 4'hF, 4'hE);
      cycle(1, 5, 8'h02, 0, 0, 0,     4'hF, 4'hE);
      idle(4);
      chk("r5_final", {24'd0, dut_rf[5]}, 32'h02);

      // Hazard on held slot and on the uncommitted write.
      cycle(1, 9, 8'h99, 0, 0, 0, 4'hF, 4'd9);
      cycle(0, 0, 0, 0, 0, 0, 4'hF, 4'd9);
      chk("hz_held", {31'd0, hazard}, 32'd1);
      cycle(0, 0, 0, 0, 0, 0, 4'hF, 4'd9);
      chk("hz_wr", {31'd0, hazard}, 32'd1);
      cycle(0, 0, 0, 0, 0, 0, 4'hF, 4'd9);
      chk("hz_clear", {31'd0, hazard}, 32'd0);

      // Randomized traffic with small address range to force collisions.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 8'($urandom),
               4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      idle(4);
      for (int r = 0; r < 4; r++) chk("rf_final", {24'd0, dut_rf[r]}, {24'd0, exp_rf[r]});
`ifdef RF_WB_ARB_STATS_EN
      chk("grant_cnt_a",  {16'd0, grant_cnt_a},  32'(m_cnt_a));
      chk("grant_cnt_b",  {16'd0, grant_cnt_b},  32'(m_cnt_b));
      chk("conflict_cnt", {16'd0, conflict_cnt}, 32'(m_conf));
`endif

      // Reset mid-burst with both slots full, then no spurious writes.
      cycle(1, 1, 8'h01, 1, 2, 8'h02, 4'hF, 4'hE);
      cycle(1, 1, 8'h03, 1, 2, 8'h04, 4'hF, 4'hE);
      do_reset();
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end
endmodule
